// File: rtl/icache_dm_blocking.sv
// Blocking direct-mapped read-only instruction cache, one 32-bit word per line.
// Single outstanding request; responses echo the request address and opaque tag.
module icache_dm_blocking #(
  parameter int p_num_lines   = 64,
  parameter int p_opaque_bits = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inv,

  input  logic                     proc_req_val,
  output logic                     proc_req_rdy,
  input  logic [31:0]              proc_req_addr,
  input  logic                     proc_req_op,
  input  logic [p_opaque_bits-1:0] proc_req_opaque,

  output logic                     proc_resp_val,
  input  logic                     proc_resp_rdy,
  output logic [31:0]              proc_resp_addr,
  output logic [31:0]              proc_resp_data,
  output logic [p_opaque_bits-1:0] proc_resp_opaque,
  output logic                     proc_resp_op,
  output logic [3:0]               proc_resp_strb,

  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [31:0]              mem_req_addr,
  output logic                     mem_req_op,
  output logic [3:0]               mem_req_strb,
  output logic [31:0]              mem_req_data,
  output logic [p_opaque_bits-1:0] mem_req_opaque,

  input  logic                     mem_resp_val,
  output logic                     mem_resp_rdy,
  input  logic [31:0]              mem_resp_data
);

  localparam int IDX_BITS = $clog2(p_num_lines);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic OP_READ = 1'b0;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_TAG         = 3'd1;
  localparam logic [2:0] S_REFILL_REQ  = 3'd2;
  localparam logic [2:0] S_REFILL_WAIT = 3'd3;
  localparam logic [2:0] S_RESP        = 3'd4;

  logic [2:0]               state_reg, state_next;
  logic [31:0]              addr_reg;
  logic [p_opaque_bits-1:0] opaque_reg;
  logic [31:0]              resp_data_reg;
  logic [p_num_lines-1:0]   valid_reg;
  logic [p_num_lines-1:0]   line_sel;

  logic [TAG_BITS-1:0]      tag_mem  [p_num_lines];
  logic [31:0]              data_mem [p_num_lines];
  logic [TAG_BITS-1:0]      tag_rd_reg;
  logic [31:0]              data_rd_reg;

  logic [IDX_BITS-1:0]      req_idx, lat_idx;
  logic [TAG_BITS-1:0]      lat_tag;
  logic                     req_fire, refill_fire, hit;

  assign req_idx = proc_req_addr[IDX_BITS+1:2];
  assign lat_idx = addr_reg[IDX_BITS+1:2];
  assign lat_tag = addr_reg[31:IDX_BITS+2];

  assign proc_req_rdy = (state_reg == S_IDLE) || ((state_reg == S_RESP) && proc_resp_rdy);
  assign req_fire     = proc_req_val && proc_req_rdy;
  assign refill_fire  = (state_reg == S_REFILL_WAIT) && mem_resp_val;
  // Tag/data were read at accept time, so TAG only needs the live valid bit.
  assign hit          = valid_reg[lat_idx] && (tag_rd_reg == lat_tag);

  for (genvar gi = 0; gi < p_num_lines; gi++) begin : g_line_sel
    assign line_sel[gi] = (lat_idx == IDX_BITS'(gi));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:        if (proc_req_val) state_next = S_TAG;
      S_TAG:         state_next = hit ? S_RESP : S_REFILL_REQ;
      S_REFILL_REQ:  if (mem_req_rdy) state_next = S_REFILL_WAIT;
      S_REFILL_WAIT: if (mem_resp_val) state_next = S_RESP;
      S_RESP:        if (proc_resp_rdy) state_next = proc_req_val ? S_TAG : S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      opaque_reg    <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        addr_reg   <= proc_req_addr;
        opaque_reg <= proc_req_opaque;
      end
      if ((state_reg == S_TAG) && hit) resp_data_reg <= data_rd_reg;
      if (refill_fire)                 resp_data_reg <= mem_resp_data;
    end
  end

  // inv takes priority over a coincident refill, leaving that line invalid.
  always_ff @(posedge clk) begin
    if (rst || inv)       valid_reg <= '0;
    else if (refill_fire) valid_reg <= valid_reg | line_sel;
  end

  always_ff @(posedge clk) begin
    if (refill_fire && !rst) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= mem_resp_data;
    end
    if (req_fire) begin
      tag_rd_reg  <= tag_mem[req_idx];
      data_rd_reg <= data_mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && req_fire) assert (proc_req_op == OP_READ);
  end

  assign proc_resp_val    = (state_reg == S_RESP);
  assign proc_resp_addr   = addr_reg;
  assign proc_resp_data   = resp_data_reg;
  assign proc_resp_opaque = opaque_reg;
  assign proc_resp_op     = OP_READ;
  assign proc_resp_strb   = 4'b0;

  assign mem_req_val    = (state_reg == S_REFILL_REQ);
  assign mem_req_addr   = {addr_reg[31:2], 2'b00};
  assign mem_req_op     = OP_READ;
  assign mem_req_strb   = 4'b0;
  assign mem_req_data   = 32'b0;
  assign mem_req_opaque = '0;
  assign mem_resp_rdy   = (state_reg == S_REFILL_WAIT);

endmodule

// File: tb/tb_icache_dm_blocking.sv
// Directed bench for icache_dm_blocking: requests push expected responses into a
// scoreboard; a monitor pops and checks them, and a memory model serves refills.
module tb_icache_dm_blocking;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv;
  logic        inv_pulse = 1'b0;
  logic        inv_on_refill = 1'b0;
  logic        proc_req_val, proc_req_rdy, proc_req_op;
  logic [31:0] proc_req_addr;
  logic [7:0]  proc_req_opaque;
  logic        proc_resp_val, proc_resp_op;
  logic        proc_resp_rdy = 1'b1;
  logic [31:0] proc_resp_addr, proc_resp_data;
  logic [7:0]  proc_resp_opaque;
  logic [3:0]  proc_resp_strb;
  logic        mem_req_val, mem_req_rdy, mem_req_op;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0]  mem_req_strb;
  logic [7:0]  mem_req_opaque;
  logic        mem_resp_val, mem_resp_rdy;
  logic [31:0] mem_resp_data;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  opq;
    logic [31:0] data;
    int          hold;
    int          lat;
    int          gap;
    int          acc;
  } item_t;

  item_t       sb[$];
  logic [31:0] mem_exp[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          held = 0;
  int          mem_lat = 3;

  assign inv = inv_pulse | (inv_on_refill & mem_resp_val);

  icache_dm_blocking #(.p_num_lines(64), .p_opaque_bits(8)) dut (
    .clk(clk), .rst(rst), .inv(inv),
    .proc_req_val(proc_req_val), .proc_req_rdy(proc_req_rdy),
    .proc_req_addr(proc_req_addr), .proc_req_op(proc_req_op),
    .proc_req_opaque(proc_req_opaque),
    .proc_resp_val(proc_resp_val), .proc_resp_rdy(proc_resp_rdy),
    .proc_resp_addr(proc_resp_addr), .proc_resp_data(proc_resp_data),
    .proc_resp_opaque(proc_resp_opaque), .proc_resp_op(proc_resp_op),
    .proc_resp_strb(proc_resp_strb),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_op(mem_req_op),
    .mem_req_strb(mem_req_strb), .mem_req_data(mem_req_data),
    .mem_req_opaque(mem_req_opaque),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h0050_0093;
      32'h0000_0204: return 32'h00a0_0113;
      32'h0000_0300: return 32'h0020_81b3;
      default:       return 32'hdead_beef;
    endcase
  endfunction

  // Issue one request; the expected response (and refill address on a miss) is queued.
  task automatic issue(input logic [31:0] a, input logic [7:0] opq, input logic [31:0] d,
                       input bit miss, input int hold, input int lat, input int gap);
    item_t it;
    int waited = 0;
    proc_req_val    = 1'b1;
    proc_req_addr   = a;
    proc_req_opaque = opq;
    if (miss) mem_exp.push_back({a[31:2], 2'b00});
    forever begin
      @(negedge clk); #1;
      if (proc_req_rdy) break;
      waited++;
      if (waited > 100) break;
    end
    if (!proc_req_rdy) begin
      checks++; errors++;
      $display("FAIL req_accept: addr %h never accepted, required acceptance", a);
    end else begin
      it.addr = a; it.opq = opq; it.data = d; it.hold = hold;
      it.lat = lat; it.gap = gap; it.acc = cyc;
      sb.push_back(it);
    end
    @(posedge clk); #1;
    proc_req_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mem_exp.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || mem_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: pending resp %0d refill %0d, required 0 and 0", sb.size(), mem_exp.size());
      sb.delete();
      mem_exp.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_inv();
    inv_pulse = 1'b1;
    @(posedge clk); #1;
    inv_pulse = 1'b0;
  endtask

  // Response-side ready for the next cycle: low while the head item still owes hold cycles.
  initial forever begin
    @(posedge clk); #1;
    proc_resp_rdy = !(sb.size() > 0 && held < sb[0].hold);
  end

  // Monitor: checks responses, stability under backpressure and request blocking.
  initial begin
    bit          seen = 0;
    int          first_cyc = 0;
    int          last_xfer = 0;
    logic [31:0] snap_addr, snap_data;
    logic [7:0]  snap_opq;
    item_t       it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && !proc_resp_val)
        check("req_rdy_in_flight", {31'b0, proc_req_rdy}, 32'h0);
      if (proc_resp_val) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: addr %h data %h, required no response", proc_resp_addr, proc_resp_data);
        end else begin
          it = sb[0];
          if (!seen) begin
            seen = 1; first_cyc = cyc;
            snap_addr = proc_resp_addr; snap_data = proc_resp_data; snap_opq = proc_resp_opaque;
          end
          if (!proc_resp_rdy) begin
            held++;
            check("hold_data", proc_resp_data, snap_data);
            check("hold_addr_opq", proc_resp_addr ^ {24'b0, proc_resp_opaque}, snap_addr ^ {24'b0, snap_opq});
            check("hold_req_rdy", {31'b0, proc_req_rdy}, 32'h0);
          end else begin
            $display("RESP addr=%h opaque=%h data=%h cyc=%0d", proc_resp_addr, proc_resp_opaque, proc_resp_data, cyc);
            check("resp_data", proc_resp_data, it.data);
            check("resp_addr", proc_resp_addr, it.addr);
            check("resp_opaque", {24'b0, proc_resp_opaque}, {24'b0, it.opq});
            check("resp_op_strb", {27'b0, proc_resp_op, proc_resp_strb}, 32'h0);
            if (it.lat >= 0) check("resp_latency", first_cyc - it.acc, it.lat);
            if (it.gap >= 0) check("resp_gap", cyc - last_xfer, it.gap);
            if (it.hold > 0) check("hold_cycles", held, it.hold);
            last_xfer = cyc;
            seen = 0;
            held = 0;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Memory model: accepts refill requests and answers mem_lat cycles later.
  initial begin
    logic [31:0] a;
    int n;
    mem_req_rdy   = 1'b1;
    mem_resp_val  = 1'b0;
    mem_resp_data = 32'b0;
    forever begin
      @(negedge clk);
      if (mem_req_val && mem_req_rdy) begin
        a = mem_req_addr;
        $display("REFILL addr=%h cyc=%0d", a, cyc);
        if (mem_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_refill: addr %h, required no refill", a);
        end else begin
          check("refill_addr", a, mem_exp.pop_front());
        end
        check("refill_fields", {31'b0, mem_req_op | (|mem_req_strb) | (|mem_req_data) | (|mem_req_opaque)}, 32'h0);
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        mem_resp_val  = 1'b1;
        mem_resp_data = mem_word(a);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!mem_resp_rdy && n < 20);
        if (!mem_resp_rdy) begin
          checks++; errors++;
          $display("FAIL refill_accept: mem_resp_rdy 0, required 1");
        end
        @(posedge clk); #1;
        mem_resp_val = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    proc_req_val = 1'b0; proc_req_addr = 32'b0; proc_req_op = 1'b0; proc_req_opaque = 8'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_rdy", {31'b0, proc_req_rdy}, 32'h1);
    check("rst_resp_val", {31'b0, proc_resp_val}, 32'h0);
    check("rst_mem_req_val", {31'b0, mem_req_val}, 32'h0);
    check("rst_mem_resp_rdy", {31'b0, mem_resp_rdy}, 32'h0);
    check("rst_latched", proc_resp_addr | proc_resp_data | {24'b0, proc_resp_opaque}, 32'h0);
    @(posedge clk); #1;

    // Cold miss, then hit.
    issue(32'h200, 8'h03, 32'h0050_0093, 1, 0, -1, -1); drain();
    issue(32'h200, 8'h04, 32'h0050_0093, 0, 0, 2, -1);  drain();
    // Fill 0x204, then back-to-back hits and an unaligned hit on the same word.
    issue(32'h204, 8'h05, 32'h00a0_0113, 1, 0, -1, -1); drain();
    issue(32'h200, 8'h10, 32'h0050_0093, 0, 0, 2, -1);
    issue(32'h204, 8'h11, 32'h00a0_0113, 0, 0, 2, 2);   drain();
    issue(32'h206, 8'h12, 32'h00a0_0113, 0, 0, 2, -1);  drain();
    // Index 0 conflict: 0x300 evicts 0x200, which then misses again.
    issue(32'h300, 8'h13, 32'h0020_81b3, 1, 0, -1, -1); drain();
    issue(32'h200, 8'h14, 32'h0050_0093, 1, 0, -1, -1); drain();
    // Backpressure for 5 cycles on a hit.
    issue(32'h200, 8'h20, 32'h0050_0093, 0, 5, 2, -1);  drain();
    // Invalidate while idle.
    pulse_inv();
    issue(32'h200, 8'h21, 32'h0050_0093, 1, 0, -1, -1); drain();
    // Invalidate coinciding with a refill write.
    inv_on_refill = 1'b1;
    issue(32'h204, 8'h22, 32'h00a0_0113, 1, 0, -1, -1); drain();
    inv_on_refill = 1'b0;
    issue(32'h204, 8'h23, 32'h00a0_0113, 1, 0, -1, -1); drain();
    issue(32'h204, 8'h24, 32'h00a0_0113, 0, 0, 2, -1);  drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
